// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: writer request channel and framebuffer RAM port seen by the arbiter.
// slave = arbiter side, master = writer/RAM side.
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 12
) ();
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   modport slave (
      input  wr_valid, wr_addr, wr_data, ram_rdata,
      output wr_ready, ram_en, ram_we, ram_addr, ram_wdata
   );
   modport master (
      output wr_valid, wr_addr, wr_data, ram_rdata,
      input  wr_ready, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port framebuffer RAM between VGA scan-out (absolute priority) and a writer.
// Define VGA_FB_UNDERFLOW_CNT_EN to add the saturating underflow_cnt output.
module vga_fb_arbiter #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int PIX_PER_WORD = 4,
   parameter int ADDR_W       = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_ce,
   input  logic        de,
   input  logic        line_start,
   input  logic        frame_start,
   output logic [2:0]  pix_rgb,
   output logic        underflow,
`ifdef VGA_FB_UNDERFLOW_CNT_EN
   output logic [15:0] underflow_cnt,
`endif
   vga_fb_arbiter_if.slave bus
);
   localparam int W        = 3 * PIX_PER_WORD;
   localparam int WPL      = H_RES / PIX_PER_WORD;
   localparam int FB_WORDS = WPL * V_RES;
   localparam int IW       = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam int LW       = $clog2(WPL + 1);

   logic [ADDR_W-1:0] next_base, fetch_addr, base;
   logic [LW-1:0]     words_left;
   logic [W-1:0]      fifo0, fifo1, f0_n, f1_n, shift_word, shifted;
   logic [1:0]        fifo_count, slot;
   logic              inflight;
   logic [IW-1:0]     pix_idx;
   logic [2:0]        pix_n;
   logic              rd_grant, wr_grant, wr_hit, need, pop, starve;

   // Credit rule: a read is only issued when the FIFO can hold it on return.
   always_comb begin
      rd_grant      = rst_n && !line_start && words_left != '0 &&
                      ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;
      wr_grant      = rst_n && !line_start && !rd_grant && bus.wr_valid;
      wr_hit        = wr_grant && bus.wr_addr < ADDR_W'(FB_WORDS);
      bus.wr_ready  = wr_grant;
      bus.ram_en    = rd_grant || wr_hit;
      bus.ram_we    = wr_hit;
      bus.ram_addr  = rd_grant ? fetch_addr : wr_hit ? bus.wr_addr : '0;
      bus.ram_wdata = wr_hit ? bus.wr_data : '0;
   end

   always_comb begin
      need    = pix_ce && de && pix_idx == '0;
      pop     = need && fifo_count != 2'd0;
      starve  = need && fifo_count == 2'd0;
      slot    = fifo_count - {1'b0, pop};
      f0_n    = (inflight && slot == 2'd0) ? bus.ram_rdata : pop ? fifo1 : fifo0;
      f1_n    = (inflight && slot == 2'd1) ? bus.ram_rdata : fifo1;
      shifted = shift_word >> (3 * pix_idx);
      pix_n   = !de ? 3'd0 : pix_idx != '0 ? shifted[2:0] : pop ? fifo0[2:0] : 3'd0;
      base    = frame_start ? '0 : next_base;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pix_rgb    <= 3'd0;
         underflow  <= 1'b0;
         next_base  <= '0;
         fetch_addr <= '0;
         words_left <= '0;
         fifo0      <= '0;
         fifo1      <= '0;
         fifo_count <= 2'd0;
         inflight   <= 1'b0;
         shift_word <= '0;
         pix_idx    <= '0;
      end else begin
         if (frame_start) begin
            next_base <= '0;
            underflow <= 1'b0;
         end
         // line_start discards any read in flight and everything buffered for the previous line.
         if (line_start) begin
            fifo_count <= 2'd0;
            inflight   <= 1'b0;
            fetch_addr <= base;
            words_left <= LW'(WPL);
            next_base  <= base + ADDR_W'(WPL);
            pix_idx    <= '0;
         end else begin
            inflight   <= rd_grant;
            fifo0      <= f0_n;
            fifo1      <= f1_n;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
            if (rd_grant) begin
               fetch_addr <= fetch_addr + 1'b1;
               words_left <= words_left - 1'b1;
            end
            if (pix_ce && de) pix_idx <= (pix_idx == IW'(PIX_PER_WORD - 1)) ? '0 : pix_idx + 1'b1;
         end
         if (pix_ce) pix_rgb <= pix_n;
         if (pop) shift_word <= fifo0;
         if (starve) begin
            shift_word <= '0;
            underflow  <= 1'b1;
         end
      end

`ifdef VGA_FB_UNDERFLOW_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) underflow_cnt <= 16'd0;
      else if (starve && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 1'b1;
`endif
endmodule
